dram_dump_controller: RTL and testbench
=======================================

Name: dram_dump_controller

Overview:
Sequencer for the counter/DRAM/UART path. On `start` it fills DEPTH words of the single-port DRAM with an incrementing byte pattern. It then reads every word back in address order and hands each byte to the UART transmitter, using the transmitter's busy flag as the handshake. It sits between the slow-clock domain's DRAM and the Transmitter, and replaces free-running counter control of `wren` and `address`.

Parameters:
ADDR_W, 16, DRAM address width
DATA_W, 8, DRAM and UART data width
DEPTH, 256, number of words filled and dumped (1..2^ADDR_W)
SEED, 0, pattern value written at address 0
ACK_TIMEOUT, 1023, max cycles to wait for tx_busy to rise after a load pulse

Ports:
clk  in  1  slow system clock (same clock as DRAM and Transmitter)
rst  in  1  asynchronous active-high reset
start  in  1  level; sampled only in IDLE/DONE, begins a fill+dump run
mem_address  out  ADDR_W  DRAM address
mem_data  out  DATA_W  DRAM write data
mem_wren  out  1  DRAM write enable
mem_q  in  DATA_W  DRAM read data, registered, valid 1 cycle after address
tx_data  out  DATA_W  byte to transmitter
tx_wr_en  out  1  one-cycle load strobe to transmitter
tx_busy  in  1  transmitter busy flag
busy  out  1  high in any state except IDLE/DONE
done  out  1  high in DONE
error  out  1  sticky handshake-timeout flag, cleared on next start or rst
state_out  out  3  current state encoding
word_count  out  ADDR_W  bytes successfully transmitted this run

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal pointer=0; timeout counter=0.
- Encoding: IDLE=0, FILL=1, RD_ADDR=2, RD_WAIT=3, TX_LOAD=4, TX_ACK=5, TX_DRAIN=6, DONE=7.
- IDLE/DONE, start=1: clear pointer, word_count and error; go to FILL. DONE with start=0 holds DONE.
- FILL: one write per cycle.
  - mem_wren=1, mem_address=ptr, mem_data=(SEED+ptr) mod 2^DATA_W.
  - ptr==DEPTH-1: write the last word, clear ptr, go to RD_ADDR. Exactly DEPTH wren cycles.
- RD_ADDR: mem_wren=0, mem_address=ptr; go to RD_WAIT.
- RD_WAIT: hold address (covers the 1-cycle read latency); go to TX_LOAD.
- TX_LOAD:
  - Wait while tx_busy=1.
  - When tx_busy=0: capture mem_q into tx_data, pulse tx_wr_en=1 for exactly one cycle, clear timeout counter, go to TX_ACK.
- TX_ACK: tx_wr_en=0; tx_data held.
  - tx_busy=1: go to TX_DRAIN.
  - Else count; counter reaches ACK_TIMEOUT: set error, go to DONE (run aborted, word_count not incremented).
- TX_DRAIN: wait for tx_busy=0, then word_count+=1.
  - ptr==DEPTH-1: go to DONE.
  - Else ptr+=1, go to RD_ADDR.
- tx_busy rising and falling within the same cycles of TX_ACK is not supported. The transmitter holds busy for at least one full clk cycle.
- Arithmetic: ptr and word_count are ADDR_W bits. For DEPTH=2^ADDR_W, the terminal test is on ptr==DEPTH-1, never on ptr wrap to 0. Pattern truncates to DATA_W and wraps 255->0.
- tx_data and mem_address stay stable outside strobes; no glitching between states.
- start asserted while busy=1 is ignored.
- rst mid-run aborts immediately. DRAM contents are left partially written; the next start refills from address 0.

Test Plan:
- rst asserted mid-FILL at ptr=37 -> outputs 0 in the same cycle (async), state_out=0, next start restarts at address 0.
- DEPTH=4, SEED=0xFE, ideal transmitter model (busy 10 cycles after strobe) -> writes FE,FF,00,01 to addresses 0..3, then tx_wr_en strobes carry FE,FF,00,01 in order; done=1, word_count=4, error=0.
- Check the fill phase -> exactly DEPTH cycles with mem_wren=1 and contiguous addresses 0..DEPTH-1; mem_wren=0 for the rest of the run.
- tx_busy held 1 when TX_LOAD entered -> no strobe until busy falls; strobe comes on the first cycle busy=0.
- Transmitter never raises busy, ACK_TIMEOUT=15 -> one strobe, error=1 after 15 TX_ACK cycles, state DONE, word_count=0; a new start clears error.
- start held high through a whole run -> single run, DONE entered, then a new run starts on the next cycle. start pulsed while busy -> ignored.

Source files
------------

// File: rtl/dram_dump_if.sv
// DRAM and UART transmitter signal bundle driven by the dump controller.
interface dram_dump_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] tx_data;
  logic              tx_wr_en;
  logic              tx_busy;

  modport master (
    output mem_address, mem_data, mem_wren, tx_data, tx_wr_en,
    input  mem_q, tx_busy
  );

  modport slave (
    input  mem_address, mem_data, mem_wren, tx_data, tx_wr_en,
    output mem_q, tx_busy
  );
endinterface

// File: rtl/dram_dump_controller.sv
// Fills the DRAM with an incrementing byte pattern, then reads every word
// back in address order and hands it to the UART transmitter, using the
// transmitter busy flag as the load handshake.
//
// state    | code | meaning
// IDLE     | 0    | waiting for start
// FILL     | 1    | one DRAM write per cycle, addresses 0..DEPTH-1
// RD_ADDR  | 2    | present read address
// RD_WAIT  | 3    | DRAM read latency
// TX_LOAD  | 4    | wait for transmitter idle, then load byte
// TX_ACK   | 5    | wait for busy to rise, bounded by ACK_TIMEOUT
// TX_DRAIN | 6    | wait for busy to fall, count the byte
// DONE     | 7    | run finished or aborted; start re-arms
module dram_dump_controller #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int SEED        = 0,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  dram_dump_if.master       bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_out,
  output logic [ADDR_W-1:0] word_count
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  // Terminal test is on the last address so DEPTH == 2**ADDR_W never relies on wrap.
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    RD_ADDR  = 3'd2,
    RD_WAIT  = 3'd3,
    TX_LOAD  = 3'd4,
    TX_ACK   = 3'd5,
    TX_DRAIN = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] txd_q, txd_d;
  logic              txw_q, txw_d;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wc_q    <= '0;
      err_q   <= 1'b0;
      txd_q   <= '0;
      txw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
      txd_q   <= txd_d;
      txw_q   <= txw_d;
    end
  end

  // Next-state and register updates; the load strobe is registered so it
  // appears together with the captured byte for exactly one cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;
    err_d   = err_q;
    txd_d   = txd_q;
    txw_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ptr_d   = '0;
          wc_d    = '0;
          err_d   = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = RD_ADDR;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: state_d = TX_LOAD;
      TX_LOAD: begin
        if (!bus.tx_busy) begin
          txd_d   = bus.mem_q;
          txw_d   = 1'b1;
          cnt_d   = '0;
          state_d = TX_ACK;
        end
      end
      TX_ACK: begin
        if (bus.tx_busy) begin
          state_d = TX_DRAIN;
        end else if (cnt_q == LAST_CNT) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_DRAIN: begin
        if (!bus.tx_busy) begin
          wc_d = wc_q + ADDR_W'(1);
          if (ptr_q == LAST_PTR) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registers so nothing glitches between states.
  always_comb begin
    bus.mem_address = ptr_q;
    bus.mem_wren    = (state_q == FILL);
    bus.mem_data    = (state_q == FILL) ? (DATA_W'(SEED) + DATA_W'(ptr_q)) : '0;
    bus.tx_data     = txd_q;
    bus.tx_wr_en    = txw_q;
    busy            = (state_q != IDLE) && (state_q != DONE);
    done            = (state_q == DONE);
    error           = err_q;
    state_out       = state_q;
    word_count      = wc_q;
  end

endmodule

// File: tb/tb_dram_dump_controller.sv
// Scoreboard bench: expected DRAM writes and transmitter loads are queued
// when a run is started; a negedge monitor pops and compares them while
// also modelling the DRAM and a randomized transmitter.
module tb_dram_dump_controller;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int SEED  = 254;
  localparam int TMO   = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, error;
  logic [2:0]    state_out;
  logic [AW-1:0] word_count;

  dram_dump_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dram_dump_controller #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .SEED(SEED), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .error(error),
    .state_out(state_out), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [DW-1:0] data; logic [AW-1:0] wc; } tx_t;

  wr_t wr_q[$];
  tx_t tx_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  strobes = 0;
  int  strobe_cyc = 0;
  int  tx_mode = 0;   // 0: randomized live transmitter, 1: never raises busy

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: writes are (SEED+i) mod 256 at address i; the k-th load carries
  // the same byte sequence with k bytes already counted.
  task automatic expect_run(input int n_tx);
    for (int i = 0; i < DEPTH; i++) wr_q.push_back('{AW'(i), DW'((SEED + i) % 256)});
    for (int i = 0; i < n_tx; i++) tx_q.push_back('{DW'((SEED + i) % 256), AW'(i)});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 6000) begin
      tick();
      n++;
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor, DRAM model and transmitter model.
  initial begin
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_pipe;
    int  busy_cnt, gap_cnt;
    bit  intf_active, strobe_due;
    wr_t we;
    tx_t te;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    rd_pipe = '0;
    busy_cnt = 0; gap_cnt = 0; intf_active = 0; strobe_due = 0;
    bus.mem_q = '0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        strobe_due = 0;
      end else begin
        if (bus.mem_wren) begin
          if (wr_q.size() == 0) check("stray_wren", 32'd1, 32'd0);
          else begin
            we = wr_q.pop_front();
            check("wr_addr", 32'(bus.mem_address), 32'(we.addr));
            check("wr_data", 32'(bus.mem_data), 32'(we.data));
          end
        end
        if (strobe_due) check("strobe_first_free", 32'(bus.tx_wr_en), 32'd1);
        if (bus.tx_wr_en) begin
          strobes++;
          strobe_cyc = cyc;
          check("strobe_busy_low", 32'(bus.tx_busy), 32'd0);
          if (tx_q.size() == 0) check("stray_strobe", 32'd1, 32'd0);
          else begin
            te = tx_q.pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(te.data));
            check("wc_at_strobe", 32'(word_count), 32'(te.wc));
          end
        end
      end
      bus.mem_q = rd_pipe;
      rd_pipe = mem[bus.mem_address];
      if (bus.mem_wren) mem[bus.mem_address] = bus.mem_data;
      if (tx_mode == 1) begin
        busy_cnt = 0;
        gap_cnt = 0;
      end else if (bus.tx_wr_en) begin
        busy_cnt = $urandom_range(1, 10);
        intf_active = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0 && !intf_active && $urandom_range(0, 1) == 1)
          gap_cnt = $urandom_range(1, 3);
      end else if (gap_cnt > 0) begin
        gap_cnt--;
        if (gap_cnt == 0) begin
          busy_cnt = $urandom_range(1, 5);
          intf_active = 1;
        end
      end
      bus.tx_busy = (busy_cnt > 0);
      strobe_due = !rst && (state_out == 3'd4) && !bus.tx_busy;
    end
  end

  initial begin
    int n, base, done_cyc;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    check("rst_wren", 32'(bus.mem_wren), 32'd0);
    check("rst_addr", 32'(bus.mem_address), 32'd0);
    check("rst_wdata", 32'(bus.mem_data), 32'd0);
    check("rst_txw", 32'(bus.tx_wr_en), 32'd0);
    check("rst_txd", 32'(bus.tx_data), 32'd0);
    rst = 1'b0;
    tick();

    // Async reset in the middle of the fill.
    expect_run(DEPTH);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(bus.mem_wren && bus.mem_address == AW'(37)) && n < 200) begin tick(); n++; end
    check("reach_ptr37", 32'(bus.mem_address), 32'd37);
    rst = 1'b1;
    #1;
    check("arst_state", 32'(state_out), 32'd0);
    check("arst_wren", 32'(bus.mem_wren), 32'd0);
    check("arst_addr", 32'(bus.mem_address), 32'd0);
    check("arst_wdata", 32'(bus.mem_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    wr_q.delete();
    tx_q.delete();
    tick();
    rst = 1'b0;
    tick();

    // Full run from address 0, with an ignored start pulse mid-run.
    base = strobes;
    expect_run(DEPTH);
    start = 1'b1; tick(); start = 1'b0;
    repeat (100) tick();
    check("busy_mid_run", 32'(busy), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    wait_done("run1");
    check("run1_error", 32'(error), 32'd0);
    check("run1_state", 32'(state_out), 32'd7);
    check("run1_wc", 32'(word_count), 32'(DEPTH % (1 << AW)));
    check("run1_strobes", 32'(strobes - base), 32'(DEPTH));
    check("run1_wr_left", 32'(wr_q.size()), 32'd0);
    check("run1_tx_left", 32'(tx_q.size()), 32'd0);

    // start held high: DONE lasts one cycle and the next run follows.
    base = strobes;
    expect_run(DEPTH);
    start = 1'b1;
    tick();
    wait_done("held1");
    check("held1_strobes", 32'(strobes - base), 32'(DEPTH));
    check("held1_wr_left", 32'(wr_q.size()), 32'd0);
    check("held1_tx_left", 32'(tx_q.size()), 32'd0);
    base = strobes;
    expect_run(DEPTH);
    tick();
    check("held_restart_state", 32'(state_out), 32'd1);
    start = 1'b0;
    wait_done("held2");
    check("held2_error", 32'(error), 32'd0);
    check("held2_strobes", 32'(strobes - base), 32'(DEPTH));
    check("held2_tx_left", 32'(tx_q.size()), 32'd0);

    // Transmitter never acknowledges: one load, then timeout abort.
    tx_mode = 1;
    base = strobes;
    expect_run(1);
    start = 1'b1; tick(); start = 1'b0;
    wait_done("tmo");
    done_cyc = cyc;
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_state", 32'(state_out), 32'd7);
    check("tmo_wc", 32'(word_count), 32'd0);
    check("tmo_strobes", 32'(strobes - base), 32'd1);
    check("tmo_ack_cycles", 32'(done_cyc - strobe_cyc), 32'(TMO));
    check("tmo_wr_left", 32'(wr_q.size()), 32'd0);

    // New start clears the sticky error and completes normally.
    tx_mode = 0;
    base = strobes;
    expect_run(DEPTH);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_err_clr", 32'(error), 32'd0);
    check("restart_state", 32'(state_out), 32'd1);
    wait_done("run2");
    check("run2_error", 32'(error), 32'd0);
    check("run2_strobes", 32'(strobes - base), 32'(DEPTH));
    check("run2_tx_left", 32'(tx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule
